vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_timing_gen_if.sv | 21 ++
 rtl/vga_timing_gen_pix_tick_div.sv | 35 +++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, coordinate widths and colour type for the VGA raster generator.
// Test-pattern colour bars are compiled in with VGA_TIMING_TEST_PATTERN_EN.
package vga_timing_pkg;

   localparam int H_VISIBLE_DEF = 800;
   localparam int H_FRONT_DEF   = 56;
   localparam int H_SYNC_DEF    = 120;
   localparam int H_BACK_DEF    = 64;
   localparam int V_VISIBLE_DEF = 600;
   localparam int V_FRONT_DEF   = 37;
   localparam int V_SYNC_DEF    = 6;
   localparam int V_BACK_DEF    = 23;

   localparam int H_TOT_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOT_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   localparam int H_COORD_W = 11;
   localparam int V_COORD_W = 10;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   // Eight vertical bars: each bit of the bar index drives one whole channel.
   function automatic rgb12_t bar_colour(input logic [2:0] idx);
      rgb12_t c;
      c.r = {4{idx[2]}};
      c.g = {4{idx[1]}};
      c.b = {4{idx[0]}};
      return c;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Coordinate/colour exchange between the raster generator (master) and the console colour logic (slave).
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic [H_COORD_W-1:0] monitor_h_coord;
   logic [V_COORD_W-1:0] monitor_v_coord;
   logic                 monitor_enable;
   logic [3:0]           monitor_r;
   logic [3:0]           monitor_g;
   logic [3:0]           monitor_b;

   modport master (
      output monitor_h_coord, monitor_v_coord, monitor_enable,
      input  monitor_r, monitor_g, monitor_b
   );

   modport slave (
      input  monitor_h_coord, monitor_v_coord, monitor_enable,
      output monitor_r, monitor_g, monitor_b
   );
endinterface

// File: rtl/vga_timing_gen_pix_tick_div.sv
// Pixel-tick divider: one-cycle pix_en_o every CLK_DIV clk cycles, held low while in reset.
module pix_tick_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic pix_en_o
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   // Next divider value, wrapping at CLK_DIV-1.
   always_comb begin
      if (div_q == DIV_MAX) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Divider register.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign pix_en_o = (div_q == DIV_MAX) && !rst;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync decode and registered VGA output stage.
// Optional VGA_TIMING_TEST_PATTERN_EN adds i_test_pattern and colour-bar substitution.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_VISIBLE = H_VISIBLE_DEF,
   parameter int   H_FRONT   = H_FRONT_DEF,
   parameter int   H_SYNC    = H_SYNC_DEF,
   parameter int   H_BACK    = H_BACK_DEF,
   parameter int   V_VISIBLE = V_VISIBLE_DEF,
   parameter int   V_FRONT   = V_FRONT_DEF,
   parameter int   V_SYNC    = V_SYNC_DEF,
   parameter int   V_BACK    = V_BACK_DEF,
   parameter logic HS_POL    = 1'b1,
   parameter logic VS_POL    = 1'b1,
   parameter int   CLK_DIV   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef VGA_TIMING_TEST_PATTERN_EN
   input  logic                    i_test_pattern,
`endif
   vga_timing_gen_if.master        mon,
   output logic [3:0]              vga_r,
   output logic [3:0]              vga_g,
   output logic [3:0]              vga_b,
   output logic                    vga_hs,
   output logic                    vga_vs,
   output logic                    o_pix_en,
   output logic                    o_frame_start,
   output logic                    o_line_start
);
   localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [H_COORD_W-1:0] H_LAST     = H_COORD_W'(H_TOT - 1);
   localparam logic [H_COORD_W-1:0] H_VIS_C    = H_COORD_W'(H_VISIBLE);
   localparam logic [H_COORD_W-1:0] HS_START_C = H_COORD_W'(H_VISIBLE + H_FRONT);
   localparam logic [H_COORD_W-1:0] HS_END_C   = H_COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [V_COORD_W-1:0] V_LAST     = V_COORD_W'(V_TOT - 1);
   localparam logic [V_COORD_W-1:0] V_VIS_C    = V_COORD_W'(V_VISIBLE);
   localparam logic [V_COORD_W-1:0] VS_START_C = V_COORD_W'(V_VISIBLE + V_FRONT);
   localparam logic [V_COORD_W-1:0] VS_END_C   = V_COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

   logic                 pix_en;
   logic [H_COORD_W-1:0] h_q, h_d;
   logic [V_COORD_W-1:0] v_q, v_d;
   logic                 en_q, en_d;
   logic                 hs_q, hs_d;
   logic                 vs_q, vs_d;
   rgb12_t               rgb_q, rgb_d;
   rgb12_t               mon_rgb;
   rgb12_t               src_rgb;
   logic                 h_last;
   logic                 v_last;

   pix_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk      (clk),
      .rst      (rst),
      .pix_en_o (pix_en)
   );

   assign h_last = (h_q == H_LAST);
   assign v_last = (v_q == V_LAST);

   // Next raster position and sync/colour for the coordinate currently presented.
   always_comb begin
      if (h_last) begin
         h_d = '0;
         v_d = v_last ? '0 : v_q + V_COORD_W'(1);
      end else begin
         h_d = h_q + H_COORD_W'(1);
         v_d = v_q;
      end
      en_d = (h_d < H_VIS_C) && (v_d < V_VIS_C);
      hs_d = ((h_q >= HS_START_C) && (h_q < HS_END_C)) ? HS_POL : ~HS_POL;
      vs_d = ((v_q >= VS_START_C) && (v_q < VS_END_C)) ? VS_POL : ~VS_POL;

      mon_rgb.r = mon.monitor_r;
      mon_rgb.g = mon.monitor_g;
      mon_rgb.b = mon.monitor_b;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      src_rgb = i_test_pattern ? bar_colour(h_q[9:7]) : mon_rgb;
`else
      src_rgb = mon_rgb;
`endif
      rgb_d = en_q ? src_rgb : '0;
   end

   // Coordinates and output stage advance together on every pixel tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q   <= '0;
         v_q   <= '0;
         en_q  <= 1'b1;
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         rgb_q <= '0;
      end else if (pix_en) begin
         h_q   <= h_d;
         v_q   <= v_d;
         en_q  <= en_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         rgb_q <= rgb_d;
      end
   end

   assign mon.monitor_h_coord = h_q;
   assign mon.monitor_v_coord = v_q;
   assign mon.monitor_enable  = en_q;

   assign vga_r  = rgb_q.r;
   assign vga_g  = rgb_q.g;
   assign vga_b  = rgb_q.b;
   assign vga_hs = hs_q;
   assign vga_vs = vs_q;

   assign o_pix_en      = pix_en;
   assign o_line_start  = pix_en && h_last;
   assign o_frame_start = pix_en && h_last && v_last;

endmodule
